// File: rtl/ring_writer_4.sv
// ring_writer_4
// Producer side of the 4-slot circular buffer between convolution pipeline
// stages. It accepts a valid/ready word stream into a ring of slots. It owns the
// write pointer and the lap bit. It follows the reader's pointer from
// single-cycle consume pulses and publishes a per-slot occupancy mask.
//
// Ports
//   Clk        rising-edge clock for all state
//   Reset      asynchronous, active-high reset
//   In_Valid   upstream word present
//   In_Data    upstream word
//   In_Ready   a word can be accepted this cycle (not full, not in reset)
//   R_Inc      reader consumed the slot at R_Addr this cycle
//   W_Addr     next slot to be written
//   R_Addr     next slot to be read
//   Round      writer is one lap ahead of the reader
//   Ready      bit i set iff slot i holds unread data
//   Count      number of unread slots, 0..4
//   Slot_Data  slot i occupies bits [i*DataWidth +: DataWidth]
//   Underflow  sticky: R_Inc seen while empty, cleared only by Reset
module ring_writer_4 #(
    parameter int DataWidth   = 8,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            In_Valid,
    input  logic [DataWidth-1:0]            In_Data,
    output logic                            In_Ready,
    input  logic                            R_Inc,
    output logic [BufferWidth-1:0]          W_Addr,
    output logic [BufferWidth-1:0]          R_Addr,
    output logic                            Round,
    output logic [BufferSize-1:0]           Ready,
    output logic [2:0]                      Count,
    output logic [BufferSize*DataWidth-1:0] Slot_Data,
    output logic                            Underflow
);

    logic [BufferWidth-1:0] w_addr;
    logic [BufferWidth-1:0] r_addr;
    logic                   round_bit;
    logic                   underflow_bit;
    logic [DataWidth-1:0]   slot [BufferSize];

    logic       full;
    logic       empty;
    logic       accept;
    logic       consume;
    logic       w_wrap;
    logic       r_wrap;
    logic [2:0] count;
    logic [3:0] fill_mask;
    logic [7:0] rot_mask;

    // The lap bit extends the write pointer, so the 3-bit difference
    // gives the occupancy directly. That includes the full case.
    assign count   = {round_bit, w_addr} - {1'b0, r_addr};
    assign full    = (w_addr == r_addr) && round_bit;
    assign empty   = (w_addr == r_addr) && !round_bit;

    assign accept  = In_Valid && In_Ready;
    assign consume = R_Inc && !empty;
    assign w_wrap  = accept  && (w_addr == 2'd3);
    assign r_wrap  = consume && (r_addr == 2'd3);

    // Occupancy mask: Count ones in the low bits, rotated left by R_Addr.
    // The pattern is rotated as a doubled copy. Bits shifted out of the top
    // copy then re-enter from the lower copy, so nothing is lost at wrap.
    always_comb begin
        fill_mask = 4'b0000;
        case (count)
            3'd0:    fill_mask = 4'b0000;
            3'd1:    fill_mask = 4'b0001;
            3'd2:    fill_mask = 4'b0011;
            3'd3:    fill_mask = 4'b0111;
            default: fill_mask = 4'b1111;
        endcase
        rot_mask = {fill_mask, fill_mask} << r_addr;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            w_addr        <= '0;
            r_addr        <= '0;
            round_bit     <= 1'b0;
            underflow_bit <= 1'b0;
            for (int i = 0; i < BufferSize; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (accept) begin
                slot[w_addr] <= In_Data;
                w_addr       <= w_addr + 1'b1;
            end
            if (consume) begin
                r_addr <= r_addr + 1'b1;
            end
            if (R_Inc && empty) begin
                underflow_bit <= 1'b1;
            end
            // Two wraps in the same cycle cancel each other.
            round_bit <= round_bit ^ (w_wrap ^ r_wrap);
        end
    end

    // Reset gates In_Ready combinationally, so the upstream side sees the
    // block drop out at once, without a clock edge.
    assign In_Ready  = !full && !Reset;
    assign W_Addr    = w_addr;
    assign R_Addr    = r_addr;
    assign Round     = round_bit;
    assign Count     = count;
    assign Ready     = rot_mask[7:4];
    assign Underflow = underflow_bit;

    for (genvar i = 0; i < BufferSize; i++) begin : g_slot_out
        assign Slot_Data[i*DataWidth +: DataWidth] = slot[i];
    end

endmodule

// File: tb/tb_ring_writer_4.sv
module tb_ring_writer_4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        In_Valid = 1'b0;
    logic [7:0]  In_Data = 8'h00;
    logic        R_Inc = 1'b0;
    logic        In_Ready;
    logic [1:0]  W_Addr;
    logic [1:0]  R_Addr;
    logic        Round;
    logic [3:0]  Ready;
    logic [2:0]  Count;
    logic [31:0] Slot_Data;
    logic        Underflow;

    ring_writer_4 dut (
        .Clk(Clk),
        .Reset(Reset),
        .In_Valid(In_Valid),
        .In_Data(In_Data),
        .In_Ready(In_Ready),
        .R_Inc(R_Inc),
        .W_Addr(W_Addr),
        .R_Addr(R_Addr),
        .Round(Round),
        .Ready(Ready),
        .Count(Count),
        .Slot_Data(Slot_Data),
        .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Model: running totals of words written and read. Pointers, lap bit and
    // occupancy all follow from these totals.
    int         wr_total;
    int         rd_total;
    logic [7:0] slot_m [4];
    logic       uf_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_total = 0;
        rd_total = 0;
        uf_m     = 1'b0;
        for (int i = 0; i < 4; i++) slot_m[i] = 8'h00;
    endtask

    task automatic model_update();
        bit acc;
        bit con;
        if (!Reset) begin
            acc = In_Valid && ((wr_total - rd_total) != 4);
            con = R_Inc && ((wr_total - rd_total) != 0);
            if (R_Inc && (wr_total == rd_total)) uf_m = 1'b1;
            if (acc) begin
                slot_m[wr_total % 4] = In_Data;
                wr_total++;
            end
            if (con) rd_total++;
        end
    endtask

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int idx;
        r = 4'b0000;
        for (int k = 0; k < wr_total - rd_total; k++) begin
            idx = (rd_total + k) % 4;
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    always @(negedge Clk) begin
        if (checking) begin
            chk("m_w_addr",   {30'd0, W_Addr}, wr_total % 4);
            chk("m_r_addr",   {30'd0, R_Addr}, rd_total % 4);
            chk("m_round",    {31'd0, Round}, ((wr_total / 4) - (rd_total / 4)) % 2);
            chk("m_count",    {29'd0, Count}, wr_total - rd_total);
            chk("m_ready",    {28'd0, Ready}, {28'd0, exp_ready()});
            chk("m_in_ready", {31'd0, In_Ready},
                {31'd0, ((wr_total - rd_total) != 4) && !Reset});
            chk("m_slots",    Slot_Data, {slot_m[3], slot_m[2], slot_m[1], slot_m[0]});
            chk("m_underflow", {31'd0, Underflow}, {31'd0, uf_m});
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic ri);
        In_Valid = v;
        In_Data  = d;
        R_Inc    = ri;
        @(posedge Clk);
        model_update();
        #2;
        In_Valid = 1'b0;
        R_Inc    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},     {28'd0, Ready}, 32'h0);
        chk({tag, "_count"},     {29'd0, Count}, 32'h0);
        chk({tag, "_in_ready"},  {31'd0, In_Ready}, 32'h0);
        chk({tag, "_w_addr"},    {30'd0, W_Addr}, 32'h0);
        chk({tag, "_r_addr"},    {30'd0, R_Addr}, 32'h0);
        chk({tag, "_round"},     {31'd0, Round}, 32'h0);
        chk({tag, "_slots"},     Slot_Data, 32'h0);
        chk({tag, "_underflow"}, {31'd0, Underflow}, 32'h0);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        model_reset();
        #1;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
    endtask

    // Mixed traffic: {In_Valid, R_Inc, data}
    logic [9:0] mix [16] = '{
        {2'b10, 8'hA1}, {2'b10, 8'hA2}, {2'b11, 8'hA3}, {2'b10, 8'hA4},
        {2'b10, 8'hA5}, {2'b10, 8'hA6}, {2'b11, 8'hA7}, {2'b01, 8'h00},
        {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00},
        {2'b11, 8'hA8}, {2'b11, 8'hA9}, {2'b10, 8'hAA}, {2'b11, 8'hAB}
    };

    initial begin
        model_reset();
        #1;
        Reset = 1'b1;
        #2;
        check_reset_values("rst0");
        checking = 1'b1;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("in_ready_after_release", {31'd0, In_Ready}, 32'h1);

        // Fill with four words
        step(1'b1, 8'h11, 1'b0);
        chk("fill1_ready", {28'd0, Ready}, 32'h1);
        chk("fill1_count", {29'd0, Count}, 32'h1);
        step(1'b1, 8'h22, 1'b0);
        chk("fill2_ready", {28'd0, Ready}, 32'h3);
        step(1'b1, 8'h33, 1'b0);
        chk("fill3_ready", {28'd0, Ready}, 32'h7);
        step(1'b1, 8'h44, 1'b0);
        chk("fill4_ready",    {28'd0, Ready}, 32'hF);
        chk("fill4_count",    {29'd0, Count}, 32'h4);
        chk("fill4_round",    {31'd0, Round}, 32'h1);
        chk("fill4_w_addr",   {30'd0, W_Addr}, 32'h0);
        chk("fill4_in_ready", {31'd0, In_Ready}, 32'h0);
        chk("fill4_slots",    Slot_Data, 32'h44332211);

        // Push against a full buffer
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0);
        chk("full_hold_slots", Slot_Data, 32'h44332211);
        step(1'b0, 8'h00, 1'b1);
        chk("drain1_r_addr",   {30'd0, R_Addr}, 32'h1);
        chk("drain1_ready",    {28'd0, Ready}, 32'hE);
        chk("drain1_in_ready", {31'd0, In_Ready}, 32'h1);

        // Wrap case
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_r_addr", {30'd0, R_Addr}, 32'h3);
        chk("wrap_round",  {31'd0, Round}, 32'h1);
        chk("wrap_ready",  {28'd0, Ready}, 32'h8);
        step(1'b1, 8'h55, 1'b0);
        chk("wrap_w_addr", {30'd0, W_Addr}, 32'h1);
        chk("wrap_ready2", {28'd0, Ready}, 32'h9);
        chk("wrap_count2", {29'd0, Count}, 32'h2);
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_r_addr0", {30'd0, R_Addr}, 32'h0);
        chk("wrap_round0",  {31'd0, Round}, 32'h0);
        chk("wrap_ready0",  {28'd0, Ready}, 32'h1);

        // Simultaneous accept and consume at Count=2
        step(1'b1, 8'h66, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b1);
            chk("simul_count", {29'd0, Count}, 32'h2);
        end

        // Underflow
        pulse_reset();
        step(1'b0, 8'h00, 1'b1);
        chk("uf_set",    {31'd0, Underflow}, 32'h1);
        chk("uf_w_addr", {30'd0, W_Addr}, 32'h0);
        chk("uf_r_addr", {30'd0, R_Addr}, 32'h0);
        chk("uf_count",  {29'd0, Count}, 32'h0);
        step(1'b1, 8'h77, 1'b1);
        chk("uf_acc_count",  {29'd0, Count}, 32'h1);
        chk("uf_acc_w_addr", {30'd0, W_Addr}, 32'h1);
        chk("uf_acc_r_addr", {30'd0, R_Addr}, 32'h0);
        step(1'b1, 8'h88, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("uf_sticky", {31'd0, Underflow}, 32'h1);

        // Mid-burst asynchronous reset at Count=3
        step(1'b1, 8'h99, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        chk("pre_rst_count", {29'd0, Count}, 32'h3);
        Reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("rst_mid");
        step(1'b1, 8'hDD, 1'b0);
        Reset = 1'b0;
        step(1'b1, 8'hBC, 1'b0);
        chk("resume_ready", {28'd0, Ready}, 32'h1);
        chk("resume_slots", Slot_Data, 32'h000000BC);

        for (int i = 0; i < 16; i++) begin
            step(mix[i][9], mix[i][7:0], mix[i][8]);
        end

        @(negedge Clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
